// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the CPU memory port and
// the memory responder.
//   master : drives req/we/addr/wdata, observes busy/done/rdata/rcmd/err
//   slave  : the responder side
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [3:0]  rcmd;
    logic        err;

    modport master (output req, we, addr, wdata,
                    input  busy, done, rdata, rcmd, err);
    modport slave  (input  req, we, addr, wdata,
                    output busy, done, rdata, rcmd, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data word memory with a fixed-latency
// req/done handshake. Returns the accessed word plus a pre-decoded 4-bit
// command code for the multicycle controller.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (memory contents kept)
//   bus   - mem_responder_if.slave: req/we/addr/wdata in,
//           busy/done/rdata/rcmd/err out (all outputs registered)
module mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2     // 1..15
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    rcmd_q, rcmd_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic [31:0]   mem_q [0:(1<<ADDR_BITS)-1];

    logic [ADDR_BITS-1:0] idx;
    logic                 fault;
    logic                 access;
    logic                 mem_we;
    logic [31:0]          word;

    assign idx    = addr_q[ADDR_BITS+1:2];
    // Misaligned, or any address bit above the array span set.
    assign fault  = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_BITS + 2)) != 32'd0);
    assign access = (state_q == WAIT) && (cnt_q == 4'd0);
    // Reset on the access edge aborts the write as well.
    assign mem_we = access && we_q && !fault && !reset;
    // Writes echo the stored word back on rdata.
    assign word   = we_q ? wdata_q : mem_q[idx];

    function automatic logic [3:0] decode(input logic [31:0] w);
        logic [3:0] c;
        c = 4'd15;
        case (w[31:26])
            6'h23: c = 4'd0;
            6'h2B: c = 4'd1;
            6'h02: c = 4'd2;
            6'h03: c = 4'd4;
            6'h04: c = 4'd5;
            6'h05: c = 4'd6;
            6'h0E: c = 4'd7;
            6'h08: c = 4'd8;
            6'h00: begin
                case (w[5:0])
                    6'h08:   c = 4'd3;
                    6'h20:   c = 4'd9;
                    6'h22:   c = 4'd10;
                    6'h2A:   c = 4'd11;
                    default: c = 4'd15;
                endcase
            end
            default: c = 4'd15;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rcmd_d  = rcmd_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    if (fault) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        rcmd_d  = 4'd15;
                    end else begin
                        err_d   = 1'b0;
                        rdata_d = word;
                        rcmd_d  = decode(word);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            rcmd_q  <= 4'd15;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rcmd_q  <= rcmd_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Captured request fields need no reset: only read after an accept.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= wdata_q;
    end

    assign bus.busy  = (state_q == WAIT) || (state_q == RESP);
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.rcmd  = rcmd_q;
    assign bus.err   = err_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory slave that services the multicycle CPU's memory port with a fixed-latency req/done handshake.
- Returns the read word together with a pre-decoded 4-bit command code. The control FSM consumes this code during fetch (memCmd) and from the instruction register (cmd).
- Sits between the CPU datapath and the backing word array, and models wait states so the controller can be verified against slow memory.

Parameters:
- ADDR_BITS, 10, log2 of memory depth in 32-bit words (1024 words).
- LATENCY, 2, wait cycles from request accept to access edge; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  access request; sampled only in IDLE
- we  in  1  1 = write, 0 = read; captured with req
- addr  in  32  byte address; captured with req
- wdata  in  32  write data; captured with req
- busy  out  1  high in WAIT and RESP
- done  out  1  one-cycle completion pulse
- rdata  out  32  read word (or written word for writes); valid while done=1, held until next done
- rcmd  out  4  decoded command code of rdata; valid with rdata
- err  out  1  access fault flag; valid while done=1

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, rdata=0, rcmd=15, err=0, counter=0. Memory contents are not cleared.
- Reset in WAIT aborts the access. The pending write is discarded and no done pulse is issued.
- States and transitions:
  - IDLE: req=1 at an edge latches we, addr, wdata; counter loads LATENCY-1; next state is WAIT. req=0 stays in IDLE.
  - WAIT: counter decrements each edge. At the edge where counter==0, the access is performed and the next state is RESP.
  - RESP: done=1 for exactly this cycle; next state is IDLE unconditionally. req is ignored in WAIT and RESP.
- Timing: accept at edge k, access at edge k+LATENCY, done high in the cycle following edge k+LATENCY. Minimum request spacing is LATENCY+2 cycles.
- Access rules:
  - Word index is addr[ADDR_BITS+1:2].
  - Fault condition: addr[1:0]!=0 or addr[31:ADDR_BITS+2]!=0.
  - On a fault: err=1, rdata=0, rcmd=15, and no write is performed.
  - Read: rdata = mem[index].
  - Write: mem[index] <= wdata at the access edge; rdata = wdata.
  - A read issued after a completed write to the same address returns the new data.
- rcmd decode, from rdata[31:26] (op) and rdata[5:0] (funct):
  - op 0x23 -> 0 (LW); op 0x2B -> 1 (SW); op 0x02 -> 2 (J); op 0x03 -> 4 (JAL)
  - op 0x04 -> 5 (BEQ); op 0x05 -> 6 (BNE); op 0x0E -> 7 (XORI); op 0x08 -> 8 (ADDI)
  - op 0x00 with funct 0x08 -> 3 (JR); funct 0x20 -> 9 (ADD); funct 0x22 -> 10 (SUB); funct 0x2A -> 11 (SLT)
  - Anything else -> 15.
  - rcmd is registered together with rdata, so both change on the same edge.
- busy=1 exactly when state is WAIT or RESP.
- done, err, rdata and rcmd are all registered outputs with no combinational path from inputs.

Test Plan:
- Reset, then read: write mem[4]=0x8C080004 via preload; req=1, we=0, addr=0x10 at edge 0 -> done high in cycle 3 (LATENCY=2) with rdata=0x8C080004, rcmd=0, err=0; busy high in cycles 1-3.
- Write then read: write addr=0x20, wdata=0x00851020 -> done with rdata=0x00851020, rcmd=9. A following read of 0x20 -> rdata=0x00851020, rcmd=9.
- Decode sweep: preload words 0x08000010, 0x03E00008, 0x0C000010, 0x15090002, 0x3908FFFF, 0xFC000000 -> rcmd values 2, 3, 4, 6, 7, 15 in order.
- Faults: read addr=0x12 -> err=1, rdata=0, rcmd=15. Write addr=0x00001000 (out of range at ADDR_BITS=10) -> err=1, and mem[0] is unchanged on readback.
- Req ignored while busy: hold req=1 continuously -> done pulses every 4 cycles (LATENCY=2); each done is exactly one cycle wide.
- Reset mid-write: accept write addr=0x8, wdata=0xDEADBEEF, assert reset one cycle later -> no done pulse, all outputs return to reset values, and a subsequent read of 0x8 returns the prior contents.
